// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requester logic and the round-robin arbiter.
// master drives enable and requests; slave (the arbiter) returns the grant.
interface rr_grant_arbiter_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  modport master (
    output en,
    output req,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  en,
    input  req,
    output grant,
    output grant_id,
    output grant_valid
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant and a hold-time
// limit that forces a handoff when another requester has been kept waiting.
module rr_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_grant_arbiter_if.slave   bus
);

  localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] MaxHoldC = HoldW'(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [3:0]       grant_q, grant_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] next_id;
  logic [3:0] others;

  // First set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign next_id = grant_id_q + 2'd1;
  assign others  = bus.req & ~grant_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        grant_id_d = 2'd0;
        hold_cnt_d = '0;
        if (bus.en && (bus.req != 4'b0000)) begin
          grant_id_d = pick(bus.req, ptr_q);
          hold_cnt_d = HoldOne;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (!bus.en) begin
          state_d    = StIdle;
          grant_id_d = 2'd0;
          hold_cnt_d = '0;
        end else if (!bus.req[grant_id_q]) begin
          ptr_d = next_id;
          if (bus.req != 4'b0000) begin
            grant_id_d = pick(bus.req, next_id);
            hold_cnt_d = HoldOne;
          end else begin
            state_d    = StIdle;
            grant_id_d = 2'd0;
            hold_cnt_d = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == MaxHoldC) && (others != 4'b0000)) begin
          // Holder still requesting; scanning from next_id finds a waiter first.
          grant_id_d = pick(bus.req, next_id);
          ptr_d      = next_id;
          hold_cnt_d = HoldOne;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q != MaxHoldC)) begin
          hold_cnt_d = hold_cnt_q + HoldOne;
        end
      end
      default: begin
        state_d    = StIdle;
        grant_id_d = 2'd0;
        hold_cnt_d = '0;
      end
    endcase

    // 2-to-4 decode of the winner, gated by the next state holding a grant.
    grant_d = (state_d == StGrant) ? (4'b0001 << grant_id_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      grant_id_q <= 2'd0;
      grant_q    <= 4'b0000;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      grant_q    <= grant_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: reset, handoff, fairness, timeout,
// lone holder saturation and enable gating, with hand-computed expectations.
module tb_rr_grant_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_grant_arbiter_if bus ();

  rr_grant_arbiter #(
    .MAX_HOLD(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en  = 1'b1;
    bus.req = 4'b0000;
    rst     = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int         seq[5];
    logic [3:0] g;
    checks  = 0;
    errors  = 0;
    seq     = '{0, 1, 2, 3, 0};
    bus.en  = 1'b1;
    bus.req = 4'b0000;
    rst     = 1'b1;
    #2;
    check("reset_grant", {4'b0, bus.grant}, 8'h00);
    check("reset_id", {6'b0, bus.grant_id}, 8'h00);
    check("reset_valid", {7'b0, bus.grant_valid}, 8'h00);
    do_reset();

    // Async reset mid-grant
    bus.req = 4'b0100;
    step();
    check("t1_grant", {4'b0, bus.grant}, 8'h04);
    check("t1_id", {6'b0, bus.grant_id}, 8'h02);
    check("t1_valid", {7'b0, bus.grant_valid}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("t1_async_clear", {4'b0, bus.grant}, 8'h00);
    check("t1_async_valid", {7'b0, bus.grant_valid}, 8'h00);
    rst     = 1'b0;
    bus.req = 4'b1111;
    step();
    check("t1_after_rst", {4'b0, bus.grant}, 8'h01);

    // No grants while disabled in idle
    do_reset();
    bus.en  = 1'b0;
    bus.req = 4'b1111;
    step();
    check("idle_en0", {4'b0, bus.grant}, 8'h00);
    bus.en = 1'b1;

    // Priority and back-to-back handoff
    do_reset();
    bus.req = 4'b1010;
    step();
    check("t2_grant", {4'b0, bus.grant}, 8'h02);
    check("t2_id", {6'b0, bus.grant_id}, 8'h01);
    bus.req = 4'b1000;
    step();
    check("t2_handoff", {4'b0, bus.grant}, 8'h08);
    check("t2_handoff_id", {6'b0, bus.grant_id}, 8'h03);

    // Fairness: each holder drops after two granted cycles
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << seq[k];
      check("t3_first", {4'b0, bus.grant}, {4'b0, g});
      step();
      check("t3_second", {4'b0, bus.grant}, {4'b0, g});
      bus.req[seq[k]] = 1'b0;
      step();
      bus.req[seq[k]] = 1'b1;
    end

    // Timeout after exactly 8 held cycles
    do_reset();
    bus.req = 4'b0001;
    step();
    check("t4_start", {4'b0, bus.grant}, 8'h01);
    bus.req = 4'b0101;
    for (int k = 0; k < 7; k++) begin
      step();
      check("t4_hold", {4'b0, bus.grant}, 8'h01);
    end
    step();
    check("t4_preempt", {4'b0, bus.grant}, 8'h04);

    // Lone holder keeps grant; saturated counter preempts immediately
    do_reset();
    bus.req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      step();
      check("t5_lone", {4'b0, bus.grant}, 8'h08);
    end
    bus.req = 4'b1001;
    step();
    check("t5_sat_preempt", {4'b0, bus.grant}, 8'h01);

    // Enable gating leaves ptr untouched (ptr=1 after release of 0)
    do_reset();
    bus.req = 4'b0011;
    step();
    check("t6_first", {4'b0, bus.grant}, 8'h01);
    bus.req = 4'b0010;
    step();
    check("t6_release", {4'b0, bus.grant}, 8'h02);
    bus.en = 1'b0;
    step();
    check("t6_disable", {4'b0, bus.grant}, 8'h00);
    check("t6_disable_valid", {7'b0, bus.grant_valid}, 8'h00);
    bus.en  = 1'b1;
    bus.req = 4'b0011;
    step();
    check("t6_reenable", {4'b0, bus.grant}, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
